req_encoder16_4: RTL



---
 rtl/req_encoder16_4_if.sv | 21 ++
 rtl/req_encoder16_4.sv | 103 ++++++++++
 2 files changed

// File: rtl/req_encoder16_4_if.sv
// Request/grant bundle between the requesters/consumer and req_encoder16_4.
// The master modport is the side that drives REQ/MASK/ACK. The slave modport is the encoder.
interface req_encoder16_4_if;
   logic [15:0] REQ;
   logic [15:0] MASK;
   logic        ACK;
   logic [3:0]  CODE;
   logic        VALID;
   logic [15:0] PENDING;
   logic        MULTI;

   modport master (
      output REQ, MASK, ACK,
      input  CODE, VALID, PENDING, MULTI
   );

   modport slave (
      input  REQ, MASK, ACK,
      output CODE, VALID, PENDING, MULTI
   );
endinterface

// File: rtl/req_encoder16_4.sv
// Sequential 16-to-4 request encoder. Pending requests are latched, masked and arbitrated.
// Each granted index is held until ACK, with one idle bubble between grants.
module req_encoder16_4 #(
   parameter int unsigned RR_MODE   = 0,
   parameter logic [3:0]  RESET_PTR = 4'd15
) (
   input logic               CLK,
   input logic               Reset,
   req_encoder16_4_if.slave  bus
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [3:0]  code_q, code_d;
   logic        valid_q, valid_d;
   logic        multi_q, multi_d;
   logic [15:0] pend_q, pend_d;

   logic [15:0] clr;
   logic [15:0] elig;
   logic [3:0]  start;
   logic [3:0]  idx;
   logic [3:0]  sel;
   logic        found;
   logic        multi;

   always_comb begin
      clr = '0;
      if (bus.ACK && valid_q) clr[code_q] = 1'b1;
      // A request arriving on the bit being cleared keeps that bit pending.
      pend_d = (pend_q & ~clr) | bus.REQ;

      elig  = pend_q & bus.MASK;
      multi = (elig & (elig - 16'd1)) != '0;

      // Fixed priority is a round-robin scan that always starts after index 15.
      start = (RR_MODE != 0) ? ptr_q : 4'd15;
      sel   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= 16; i++) begin
         idx = start + i[3:0];
         if (!found && elig[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end

      state_d = state_q;
      ptr_d   = ptr_q;
      code_d  = code_q;
      valid_d = valid_q;
      multi_d = multi_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               code_d  = sel;
               valid_d = 1'b1;
               multi_d = multi;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (bus.ACK) begin
               valid_d = 1'b0;
               ptr_d   = code_q;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         ptr_q   <= RESET_PTR;
         code_q  <= '0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.CODE    = code_q;
   assign bus.VALID   = valid_q;
   assign bus.PENDING = pend_q;
   assign bus.MULTI   = multi_q;

endmodule
